// File: rtl/reduce_stream_pkg.sv
// ---------------------------------------------------------------------------
// reduce_stream_pkg
// Shared definitions for the reduce_sum stream source:
//   state_t        - controller states (IDLE, SEND, WAIT_RES)
//   DATA_W_DEF     - default stream word width
//   LFSR_MASK      - Galois feedback mask for the 16-bit throttle generator
//   LFSR_SEED_DEF  - default (non-zero) generator reload value
//   lfsr_step()    - one Galois step: shift right, fold mask in on a 1 out
// ---------------------------------------------------------------------------
package reduce_stream_pkg;

  localparam int          DATA_W_DEF    = 32;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used as a pseudo-random stall/gap pattern generator.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (reset loads seed)
//   load      - reload the register from seed (has priority over advance)
//   seed      - reload value; must be non-zero
//   advance   - step the generator once this cycle
//   state     - current generator contents
// ---------------------------------------------------------------------------
module lfsr16
  import reduce_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_reg;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state_reg <= seed;
    end else if (advance) begin
      state_reg <= lfsr_step(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/reduce_stream_tx.sv
// ---------------------------------------------------------------------------
// reduce_stream_tx
// Holds a BUFFER_DEPTH-word vector, streams it to reduce_sum (optionally with
// LFSR-driven gaps), then waits for the reducer result and checks it against
// its own modulo-2^DATA_W sum of the transmitted words.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data     - vector buffer write port (IDLE only)
//   start, throttle_en        - launch pulse (IDLE only), gap enable at launch
//   out_data, out_valid       - stream to reduce_sum in_data / in_valid
//   sum_data, sum_valid       - reducer result (observed in WAIT_RES only)
//   busy, done                - run in progress, one-cycle end-of-run pulse
//   match, timeout, result    - run outcome, held until the next start
//   expected_sum              - running sum of transmitted words
// ---------------------------------------------------------------------------
module reduce_stream_tx
  import reduce_stream_pkg::*;
#(
  parameter int          BUFFER_DEPTH = 512,
  parameter int          DATA_W       = DATA_W_DEF,
  parameter int          TIMEOUT      = 1024,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(BUFFER_DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            start,
  input  logic                            throttle_en,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic [DATA_W-1:0]               sum_data,
  input  logic                            sum_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            match,
  output logic                            timeout,
  output logic [DATA_W-1:0]               expected_sum,
  output logic [DATA_W-1:0]               result
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W-1:0] mem [BUFFER_DEPTH];

  state_t            state_reg, state_next;
  logic [AW-1:0]     index_reg;
  logic [CW-1:0]     cnt_reg;
  logic              throttle_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              done_reg, match_reg, timeout_reg;
  logic [DATA_W-1:0] expected_sum_reg, result_reg;

  logic              issue, lfsr_load, lfsr_adv, res_hit, to_hit, launch;
  logic [15:0]       lfsr_state;
  logic [DATA_W-1:0] exp_total;
  logic              unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // Only bit 0 gates issue; the rest of the generator state is not needed.
  assign unused_lfsr_bits = ^lfsr_state[15:1];

  // The sum accumulates the registered stream word, so it trails the issue
  // edge by one cycle. exp_total folds in the word still in flight, which is
  // what a result arriving in the first WAIT_RES cycle must be compared with.
  assign exp_total = expected_sum_reg + (out_valid_reg ? out_data_reg : '0);
  assign launch    = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    res_hit    = 1'b0;
    to_hit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          lfsr_load  = 1'b1;
        end
      end
      SEND: begin
        lfsr_adv = 1'b1;
        issue    = !throttle_reg || lfsr_state[0];
        if (issue && (index_reg == AW'(BUFFER_DEPTH - 1))) begin
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result on the timeout cycle still counts as a result.
        if (sum_valid) begin
          res_hit    = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          to_hit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      index_reg        <= '0;
      cnt_reg          <= '0;
      throttle_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      done_reg         <= 1'b0;
      match_reg        <= 1'b0;
      timeout_reg      <= 1'b0;
      expected_sum_reg <= '0;
      result_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      out_valid_reg    <= issue;
      done_reg         <= res_hit || to_hit;
      expected_sum_reg <= exp_total;
      cnt_reg          <= (state_reg == WAIT_RES) ? cnt_reg + 1'b1 : '0;
      if (issue) begin
        index_reg <= index_reg + 1'b1;
      end
      if (launch) begin
        index_reg        <= '0;
        throttle_reg     <= throttle_en;
        expected_sum_reg <= '0;
        result_reg       <= '0;
        match_reg        <= 1'b0;
        timeout_reg      <= 1'b0;
      end
      if (res_hit) begin
        result_reg <= sum_data;
        match_reg  <= (sum_data == exp_total);
      end
      if (to_hit) begin
        timeout_reg <= 1'b1;
        match_reg   <= 1'b0;
      end
    end
  end

  // Vector buffer: write port open only in IDLE, registered read into the
  // stream output. A non-issue cycle zeroes the output register.
  always_ff @(posedge clk) begin
    if ((state_reg == IDLE) && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
    end else begin
      out_data_reg <= issue ? mem[index_reg] : '0;
    end
  end

  assign out_data     = out_data_reg;
  assign out_valid    = out_valid_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign match        = match_reg;
  assign timeout      = timeout_reg;
  assign expected_sum = expected_sum_reg;
  assign result       = result_reg;

endmodule
